// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: controller state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter must index 0..width-1 and never collapse to zero bits.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl; slave = adder, master = requester.
// Optional subtract-select signal present only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic [WIDTH-1:0] sum_out;
  logic             cout;
  logic             overflow;
  logic             done_valid;
  logic             done_ready;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start_valid, a_in, b_in, cin, done_ready,
    output start_ready, busy, sum_out, cout, overflow, done_valid
  );

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start_valid, a_in, b_in, cin, done_ready,
    input  start_ready, busy, sum_out, cout, overflow, done_valid
  );

endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// Combinational 1-bit full adder cell shared by the serial datapath; zero latency, no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic ca
);

  assign s  = a ^ b ^ c;
  assign ca = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: WIDTH cycles LSB-first through one full_adder; result held until done_ready.
// Latency WIDTH cycles after accept; SERIAL_ADDER_SUB_EN adds a subtract mode (sub port).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_ca;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_b_load;
  logic             w_cin_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction as a + ~b + 1; cout then reads as "no borrow".
  assign w_b_load   = bus.sub ? ~bus.b_in : bus.b_in;
  assign w_cin_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign w_b_load   = bus.b_in;
  assign w_cin_load = bus.cin;
`endif

  assign w_last = (r_cnt == LAST);

  full_adder u_fa (
    .a  (r_a_sh[0]),
    .b  (r_b_sh[0]),
    .c  (r_carry),
    .s  (w_s),
    .ca (w_ca)
  );

  always_comb begin
    w_next_state    = r_state;
    w_accept        = 1'b0;
    bus.start_ready = 1'b0;
    bus.busy        = 1'b0;
    bus.done_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        bus.done_valid = 1'b1;
        if (bus.done_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= bus.a_in;
      r_b_sh  <= w_b_load;
      r_carry <= w_cin_load;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      // Sum bit enters at the MSB; after WIDTH shifts bit 0 lands in place.
      r_sum_sh <= WIDTH'({w_s, r_sum_sh} >> 1);
      r_carry  <= w_ca;
      if (w_last) begin
        r_cout <= w_ca;
        r_ovf  <= r_carry ^ w_ca;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.sum_out  = r_sum_sh;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;

endmodule
